// File: rtl/rr_dispatcher.sv
// rr_dispatcher
//   1:N round-robin dispatcher. A single valid/ready input stream is buffered
//   in a one-entry holding register and each held item is handed to the next
//   ready output port, scanning in rotating order starting just after the
//   last port served.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   stall      freezes dispatch and the pointer; an empty buffer may still fill
//   in_valid   input item valid
//   in_ready   input accepted when in_valid && in_ready
//   in_data    input payload
//   out_valid  one-hot (or zero) dispatch strobe, one bit per port
//   out_ready  per-port ready
//   out_data   held payload, broadcast to every port
//   out_idx    binary index of the port being served, 0 when idle
//   busy       holding register occupied
module rr_dispatcher #(
    parameter int PORT = 4,
    parameter int DATA = 32,
    localparam int IDX = $clog2(PORT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_data,
    output logic [PORT-1:0] out_valid,
    input  logic [PORT-1:0] out_ready,
    output logic [DATA-1:0] out_data,
    output logic [IDX-1:0]  out_idx,
    output logic            busy
);

    logic            r_valid;
    logic [DATA-1:0] r_data;
    logic [IDX-1:0]  r_next;

    logic [IDX-1:0]  sel;
    logic            cand_exist;
    logic            fire;
    logic [IDX-1:0]  sel_inc;

    // Rotating priority scan. The candidate index wraps modulo PORT, so for a
    // non-power-of-2 PORT the unused codes PORT..2^IDX-1 are never produced.
    always_comb begin
        int unsigned p;
        logic        found;
        sel   = '0;
        found = 1'b0;
        p     = 0;
        for (int unsigned k = 0; k < PORT; k++) begin
            p = int'(r_next) + k;
            if (p >= PORT) p = p - PORT;
            if (!found && out_ready[p[IDX-1:0]]) begin
                found = 1'b1;
                sel   = p[IDX-1:0];
            end
        end
    end

    assign cand_exist = |out_ready;
    assign fire       = r_valid && !stall && cand_exist;
    assign sel_inc    = (sel == IDX'(PORT - 1)) ? '0 : sel + IDX'(1);

    assign out_valid = fire ? (PORT'(1) << sel) : '0;
    assign out_idx   = fire ? sel : '0;
    assign out_data  = r_data;
    assign in_ready  = !r_valid || fire;
    assign busy      = r_valid;

    // Accept takes precedence over the fire-clear so that a simultaneous
    // dispatch and accept reloads the buffer (pass-through at full rate).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_next  <= '0;
        end else begin
            if (in_valid && in_ready) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
            end else if (fire) begin
                r_valid <= 1'b0;
            end
            if (fire) begin
                r_next <= sel_inc;
            end
        end
    end

endmodule

// File: tb/tb_rr_dispatcher.sv
module tb_rr_dispatcher;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: PORT=4, DATA=8
    logic       stall_a = 1'b0;
    logic       in_valid_a = 1'b0;
    logic       in_ready_a;
    logic [7:0] in_data_a = '0;
    logic [3:0] out_valid_a;
    logic [3:0] out_ready_a = '1;
    logic [7:0] out_data_a;
    logic [1:0] out_idx_a;
    logic       busy_a;

    // Instance B: PORT=3, DATA=8
    logic       stall_b = 1'b0;
    logic       in_valid_b = 1'b0;
    logic       in_ready_b;
    logic [7:0] in_data_b = '0;
    logic [2:0] out_valid_b;
    logic [2:0] out_ready_b = '1;
    logic [7:0] out_data_b;
    logic [1:0] out_idx_b;
    logic       busy_b;

    rr_dispatcher #(.PORT(4), .DATA(8)) dut_a (
        .clk(clk), .reset(reset), .stall(stall_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_idx(out_idx_a), .busy(busy_a)
    );

    rr_dispatcher #(.PORT(3), .DATA(8)) dut_b (
        .clk(clk), .reset(reset), .stall(stall_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_idx(out_idx_b), .busy(busy_b)
    );

    typedef struct {
        int port;
        int data;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic void chk(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    endfunction

    // Scoreboard monitors: pop one expectation per dispatch strobe.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_a != '0) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_dispatch", int'(out_valid_a), 0);
                end else begin
                    exp_t e;
                    e = exp_a.pop_front();
                    chk("a_out_idx", int'(out_idx_a), e.port);
                    chk("a_out_valid", int'(out_valid_a), 1 << e.port);
                    chk("a_out_data", int'(out_data_a), e.data);
                end
            end else begin
                chk("a_idle_idx", int'(out_idx_a), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_b != '0) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_dispatch", int'(out_valid_b), 0);
                end else begin
                    exp_t e;
                    e = exp_b.pop_front();
                    chk("b_out_idx", int'(out_idx_b), e.port);
                    chk("b_out_valid", int'(out_valid_b), 1 << e.port);
                    chk("b_out_data", int'(out_data_b), e.data);
                end
            end else begin
                chk("b_idle_idx", int'(out_idx_b), 0);
            end
        end
    end

    // Offer one item; port < 0 means it must never be dispatched.
    task automatic push_a(input logic [7:0] d, input int port, input bit must_ready);
        int n;
        n = 0;
        in_valid_a = 1'b1;
        in_data_a  = d;
        if (port >= 0) exp_a.push_back('{port, int'(d)});
        @(negedge clk);
        if (must_ready) chk("a_in_ready_stream", int'(in_ready_a), 1);
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) chk("a_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d, input int port);
        int n;
        n = 0;
        in_valid_b = 1'b1;
        in_data_b  = d;
        exp_b.push_back('{port, int'(d)});
        @(negedge clk);
        while (!in_ready_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_b) chk("b_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        idle(2);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_idx", int'(out_idx_a), 0);
        chk("rst_out_data", int'(out_data_a), 0);
        chk("rst_in_ready", int'(in_ready_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        @(posedge clk);
        #1;

        // All ready, streaming: ports 0,1,2,3,0 at full rate
        out_ready_a = 4'b1111;
        for (int i = 0; i < 5; i++) push_a(8'h10 + 8'(i), i % 4, 1'b1);

        // out_ready=0101: ports 0,2,0,2
        do_reset();
        out_ready_a = 4'b0101;
        push_a(8'h20, 0, 1'b0);
        push_a(8'h21, 2, 1'b1);
        push_a(8'h22, 0, 1'b1);
        push_a(8'h23, 2, 1'b1);

        // No port ready: item held, then only port 3 ready
        do_reset();
        out_ready_a = 4'b0000;
        push_a(8'h30, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("noready_busy", int'(busy_a), 1);
            chk("noready_in_ready", int'(in_ready_a), 0);
            chk("noready_out_valid", int'(out_valid_a), 0);
        end
        @(posedge clk);
        #1;
        out_ready_a = 4'b1000;
        @(negedge clk);
        chk("port3_in_ready", int'(in_ready_a), 1);
        chk("port3_out_valid", int'(out_valid_a), 8);
        @(posedge clk);
        #1;
        out_ready_a = 4'b1111;
        push_a(8'h31, 0, 1'b0);  // pointer wrapped to 0

        // Stall: pointer frozen at 1 while held
        do_reset();
        out_ready_a = 4'b1111;
        push_a(8'h41, 0, 1'b0);
        idle(1);
        stall_a = 1'b1;
        push_a(8'h42, 1, 1'b1);  // empty buffer still fills under stall
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid_a), 0);
            chk("stall_in_ready", int'(in_ready_a), 0);
            chk("stall_busy", int'(busy_a), 1);
        end
        @(posedge clk);
        #1;
        stall_a = 1'b0;
        @(negedge clk);
        chk("unstall_out_valid", int'(out_valid_a), 2);

        // Reset while holding an item: it is dropped, pointer back to 0
        do_reset();
        out_ready_a = 4'b1111;
        push_a(8'h43, 0, 1'b0);  // moves pointer to 1 before the reset
        idle(1);
        out_ready_a = 4'b0000;
        push_a(8'h50, -1, 1'b0);
        @(negedge clk);
        chk("prerst_busy", int'(busy_a), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_busy", int'(busy_a), 0);
        chk("postrst_in_ready", int'(in_ready_a), 1);
        @(posedge clk);
        #1;
        out_ready_a = 4'b1111;
        push_a(8'h51, 0, 1'b0);

        // PORT=3: 7 items, ports 0,1,2,0,1,2,0
        do_reset();
        out_ready_b = 3'b111;
        for (int i = 0; i < 7; i++) push_b(8'h60 + 8'(i), i % 3);

        // PORT=3 wrap with single ready ports: pointer 1 -> port 2 -> wraps to 0
        idle(2);
        out_ready_b = 3'b100;
        push_b(8'h70, 2);
        idle(1);
        out_ready_b = 3'b011;
        push_b(8'h71, 0);

        idle(4);
        chk("a_queue_drained", exp_a.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
